// File: rtl/mips_mem_if.sv
// mips_mem_if: data-bus bundle between the MEM stage and data memory.
//   req    master->slave  request, held until gnt
//   we     master->slave  1=write, 0=read
//   addr   master->slave  byte address
//   wdat   master->slave  write data
//   gnt    slave->master  request accepted this cycle
//   rvalid slave->master  read data valid
//   rdata  slave->master  read data
interface mips_mem_if #(
   parameter int ADDR_W = 32,
   parameter int DATA_W = 32
);
   logic              req;
   logic              we;
   logic [ADDR_W-1:0] addr;
   logic [DATA_W-1:0] wdat;
   logic              gnt;
   logic              rvalid;
   logic [DATA_W-1:0] rdata;

   modport master (output req, we, addr, wdat, input gnt, rvalid, rdata);
   modport slave  (input req, we, addr, wdat, output gnt, rvalid, rdata);
endinterface

// File: rtl/mips_mem.sv
// mips_mem: MEM stage of the 5-stage pipeline.
//   Takes the registered EX->MEM bundle (ex2mem_*), performs the load/store on
//   the req/gnt/rvalid data bus and registers the MEM->WB bundle (mem2wb_*).
//   Load data replaces the ALU result for reads; non-memory ops pass through
//   with one cycle of latency. mem_stall (comb.) freezes IF/ID/EX while an
//   access is in flight; upstream holds ex2mem_* stable meanwhile.
// Ports:
//   clk, rst          clock, synchronous active-high reset
//   ex2mem_*          load/store request, address, store data, rd idx/data/wen
//   mem_stall         comb. stall to upstream stages
//   dbus              mips_mem_if master modport (data bus)
//   mem2wb_*          registered rd idx/data/wen to writeback
//   mem_misalign      registered 1-cycle pulse on a misaligned access
// Optional feature: define MIPS_MEM_ALIGN_CHK_EN to suppress accesses with
//   addr[1:0]!=0 and flag them on mem_misalign; otherwise mem_misalign is 0.
`ifndef MIPS_DATA_WIDTH
`define MIPS_DATA_WIDTH 32
`endif
`ifndef MIPS_ADDR_WIDTH
`define MIPS_ADDR_WIDTH 32
`endif
`ifndef MIPS_RFIDX_WIDTH
`define MIPS_RFIDX_WIDTH 5
`endif

module mips_mem #(
   parameter int DATA_W  = `MIPS_DATA_WIDTH,
   parameter int ADDR_W  = `MIPS_ADDR_WIDTH,
   parameter int RFIDX_W = `MIPS_RFIDX_WIDTH
) (
   input  logic               clk,
   input  logic               rst,
   input  logic               ex2mem_mem_read,
   input  logic               ex2mem_mem_write,
   input  logic [ADDR_W-1:0]  ex2mem_mem_addr,
   input  logic [DATA_W-1:0]  ex2mem_mem_wdat,
   input  logic [RFIDX_W-1:0] ex2mem_rd_idx,
   input  logic [DATA_W-1:0]  ex2mem_rd_wdat,
   input  logic               ex2mem_rd_wen,
   output logic               mem_stall,
   mips_mem_if.master         dbus,
   output logic [RFIDX_W-1:0] mem2wb_rd_idx,
   output logic [DATA_W-1:0]  mem2wb_rd_wdat,
   output logic               mem2wb_rd_wen,
   output logic               mem_misalign
);

   typedef enum logic [1:0] {IDLE, REQ, RESP} state_t;
   state_t state, state_n;

   logic rd, wr, misalign, access, done;

   // Read wins when both strobes are set; the write is dropped.
   assign rd = ex2mem_mem_read;
   assign wr = ex2mem_mem_write & ~ex2mem_mem_read;

`ifdef MIPS_MEM_ALIGN_CHK_EN
   assign misalign = (rd | wr) & (ex2mem_mem_addr[1:0] != 2'b00);
`else
   assign misalign = 1'b0;
`endif

   // A misaligned access is squashed: it never reaches the bus or stalls.
   assign access = (rd | wr) & ~misalign;

   assign dbus.addr = ex2mem_mem_addr;
   assign dbus.we   = wr;
   assign dbus.wdat = ex2mem_mem_wdat;
   assign dbus.req  = access & (state != RESP);

   // Stores finish on gnt; loads finish on rvalid, which only counts in RESP
   // so a stray rvalid before the grant cannot complete a load.
   assign done      = (state != RESP) ? (access & wr & dbus.gnt)
                                      : (access & dbus.rvalid);
   assign mem_stall = access & ~done;

   always_ff @(posedge clk) begin
      if (rst) state <= IDLE;
      else     state <= state_n;
   end

   always_comb begin
      state_n = state;
      case (state)
         IDLE, REQ: begin
            if (!access)       state_n = IDLE;
            else if (dbus.gnt) state_n = rd ? RESP : IDLE;
            else               state_n = REQ;
         end
         RESP: if (dbus.rvalid) state_n = IDLE;
         default: state_n = IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         mem2wb_rd_idx  <= '0;
         mem2wb_rd_wdat <= '0;
         mem2wb_rd_wen  <= 1'b0;
         mem_misalign   <= 1'b0;
      end else begin
         mem_misalign <= misalign;
         if (mem_stall) begin
            // Bubble: keep idx/data, just suppress the write.
            mem2wb_rd_wen <= 1'b0;
         end else begin
            mem2wb_rd_idx  <= ex2mem_rd_idx;
            mem2wb_rd_wdat <= (rd && !misalign) ? dbus.rdata : ex2mem_rd_wdat;
            mem2wb_rd_wen  <= ex2mem_rd_wen & ~misalign;
         end
      end
   end

endmodule

// File: tb/tb_mips_mem.sv
// tb_mips_mem: directed scoreboard bench for mips_mem. Stimulus pushes the
// expected writeback (idx,data) into a queue; a monitor pops and compares
// every cycle mem2wb_rd_wen is seen high.
module tb_mips_mem;
   logic        clk = 1'b0;
   logic        rst;
   logic        mem_read, mem_write;
   logic [31:0] mem_addr, mem_wdat, rd_wdat;
   logic [4:0]  rd_idx;
   logic        rd_wen;
   logic        mem_stall;
   logic [4:0]  wb_idx;
   logic [31:0] wb_wdat;
   logic        wb_wen;
   logic        misalign;

   mips_mem_if #(.ADDR_W(32), .DATA_W(32)) dbus ();

   mips_mem dut (
      .clk              (clk),
      .rst              (rst),
      .ex2mem_mem_read  (mem_read),
      .ex2mem_mem_write (mem_write),
      .ex2mem_mem_addr  (mem_addr),
      .ex2mem_mem_wdat  (mem_wdat),
      .ex2mem_rd_idx    (rd_idx),
      .ex2mem_rd_wdat   (rd_wdat),
      .ex2mem_rd_wen    (rd_wen),
      .mem_stall        (mem_stall),
      .dbus             (dbus),
      .mem2wb_rd_idx    (wb_idx),
      .mem2wb_rd_wdat   (wb_wdat),
      .mem2wb_rd_wen    (wb_wen),
      .mem_misalign     (misalign)
   );

   always #5 clk = ~clk;

   int checks = 0;
   int failures = 0;
   logic [36:0] exp_q[$];   // {idx, wdat}

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s: got %h expected %h", name, act, exp);
      end
   endtask

   // Advance one clock; inputs change 1 time unit after the rising edge.
   task automatic step();
      @(posedge clk);
      #1;
   endtask

   // Comb outputs are sampled a few units after inputs settle.
   task automatic chk_bus(input string name, input logic req, input logic stall);
      #3;
      chk({name, "_req"}, {31'b0, dbus.req}, {31'b0, req});
      chk({name, "_stall"}, {31'b0, mem_stall}, {31'b0, stall});
   endtask

   task automatic idle_in();
      mem_read = 0; mem_write = 0; mem_addr = 0; mem_wdat = 0;
      rd_idx = 0; rd_wdat = 0; rd_wen = 0;
      dbus.gnt = 0; dbus.rvalid = 0; dbus.rdata = 32'h0BAD_0BAD;
   endtask

   // Monitor: every writeback must match the next scoreboard entry.
   initial begin
      forever begin
         @(negedge clk);
         if (wb_wen === 1'b1) begin
            if (exp_q.size() == 0) begin
               chk("wb_unexpected", {27'b0, wb_idx}, 32'hFFFF_FFFF);
            end else begin
               logic [36:0] e;
               e = exp_q.pop_front();
               chk("wb_idx", {27'b0, wb_idx}, {27'b0, e[36:32]});
               chk("wb_wdat", wb_wdat, e[31:0]);
            end
         end
      end
   end

   initial begin
      int stalls;
      idle_in();
      rst = 1;
      step(); step();
      #3;
      chk("rst_req", {31'b0, dbus.req}, 32'd0);
      chk("rst_stall", {31'b0, mem_stall}, 32'd0);
      chk("rst_wb_idx", {27'b0, wb_idx}, 32'd0);
      chk("rst_wb_wdat", wb_wdat, 32'd0);
      chk("rst_wb_wen", {31'b0, wb_wen}, 32'd0);
      chk("rst_misalign", {31'b0, misalign}, 32'd0);
      step();
      rst = 0;

      // 1. ALU op passes through in one cycle.
      rd_idx = 3; rd_wdat = 32'h1234; rd_wen = 1;
      exp_q.push_back({5'd3, 32'h1234});
      chk_bus("alu", 0, 0);
      step();
      idle_in();
      step();

      // 2. Zero-wait store: req/we for one cycle, no stall.
      mem_write = 1; mem_addr = 32'h40; mem_wdat = 32'hDEAD_BEEF; dbus.gnt = 1;
      chk_bus("st0", 1, 0);
      chk("st0_we", {31'b0, dbus.we}, 32'd1);
      chk("st0_addr", dbus.addr, 32'h40);
      chk("st0_wdat", dbus.wdat, 32'hDEAD_BEEF);
      step();
      idle_in();
      chk_bus("st0_after", 0, 0);
      step();

      // Store with one wait state: stalls in the first cycle only.
      mem_write = 1; mem_addr = 32'h48; rd_idx = 2; rd_wdat = 32'hABCD; rd_wen = 1;
      exp_q.push_back({5'd2, 32'hABCD});
      chk_bus("st1_c0", 1, 1);
      step();
      dbus.gnt = 1;
      chk_bus("st1_c1", 1, 0);
      step();
      idle_in();
      step();

      // 3. Load: gnt after 2 cycles, rvalid 3 cycles later; a stray rvalid
      //    before the grant must be ignored.
      mem_read = 1; mem_addr = 32'h80; rd_idx = 7; rd_wdat = 32'h1111; rd_wen = 1;
      exp_q.push_back({5'd7, 32'hCAFE_F00D});
      stalls = 0;
      for (int c = 0; c < 6; c++) begin
         dbus.gnt    = (c == 2);
         dbus.rvalid = (c == 1) || (c == 5);
         dbus.rdata  = (c == 5) ? 32'hCAFE_F00D : 32'h0BAD_0BAD;
         chk_bus($sformatf("ld_c%0d", c), c <= 2, c < 5);
         if (mem_stall) stalls++;
         step();
      end
      chk("ld_stall_cycles", stalls, 32'd5);
      idle_in();
      step();

      // 4. Reset while waiting for read data; the late rvalid is dropped.
      mem_read = 1; mem_addr = 32'h100; rd_idx = 9; rd_wdat = 32'h9999; rd_wen = 1;
      dbus.gnt = 1;
      chk_bus("rr_c0", 1, 1);
      step();
      dbus.gnt = 0;
      chk_bus("rr_resp", 0, 1);
      rst = 1;
      step();
      rst = 0;
      idle_in();
      dbus.rvalid = 1; dbus.rdata = 32'h5555_5555;
      chk_bus("rr_post", 0, 0);
      chk("rr_wb_idx", {27'b0, wb_idx}, 32'd0);
      chk("rr_wb_wdat", wb_wdat, 32'd0);
      chk("rr_wb_wen", {31'b0, wb_wen}, 32'd0);
      step();
      idle_in();
      step();

      // 5. Read and write together behave as a load.
      mem_read = 1; mem_write = 1; mem_addr = 32'h44; mem_wdat = 32'h1; 
      rd_idx = 4; rd_wdat = 32'h44; rd_wen = 1; dbus.gnt = 1;
      exp_q.push_back({5'd4, 32'h0000_55AA});
      chk_bus("rw_c0", 1, 1);
      chk("rw_we", {31'b0, dbus.we}, 32'd0);
      step();
      dbus.gnt = 0; dbus.rvalid = 1; dbus.rdata = 32'h55AA;
      chk_bus("rw_c1", 0, 0);
      step();
      idle_in();
      step();

      // 6. Misaligned load to 0x42.
      mem_read = 1; mem_addr = 32'h42; rd_idx = 5; rd_wdat = 32'h42; rd_wen = 1;
`ifdef MIPS_MEM_ALIGN_CHK_EN
      chk_bus("mis", 0, 0);
      step();
      idle_in();
      #3;
      chk("mis_pulse", {31'b0, misalign}, 32'd1);
      step();
      #3;
      chk("mis_pulse_end", {31'b0, misalign}, 32'd0);
`else
      dbus.gnt = 1;
      exp_q.push_back({5'd5, 32'h77});
      chk_bus("mis", 1, 1);
      chk("mis_addr", dbus.addr, 32'h42);
      step();
      dbus.gnt = 0; dbus.rvalid = 1; dbus.rdata = 32'h77;
      chk_bus("mis_c1", 0, 0);
      chk("mis_flag", {31'b0, misalign}, 32'd0);
      step();
      idle_in();
      step();
`endif
      step(); step();
      chk("scoreboard_empty", exp_q.size(), 32'd0);
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end
endmodule
